// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer: EPC save, cause/status update, vector and eret redirect.
// Optional external interrupt path is compiled in with EXC_IRQ_EN.
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        instr_valid,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_ov,
  input  logic        eret,
`ifdef EXC_IRQ_EN
  input  logic        irq,
`endif
  input  logic [31:0] epc_in,
  output logic        epc_write,
  output logic [31:0] epc_pc,
  output logic [31:0] cause,
  output logic [31:0] status,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RET} state_t;

  localparam logic [31:0] VECTOR_PC = 32'h0000_0800;

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [4:0]  cause_q, cause_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        epc_write_q, epc_write_d;
  logic [31:0] epc_pc_q, epc_pc_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        stall_q, stall_d;

  logic irq_w;
  logic sync_exc;
  logic take_irq;

`ifdef EXC_IRQ_EN
  assign irq_w = irq;
`else
  assign irq_w = 1'b0;
`endif

  always_comb begin
    sync_exc      = instr_valid & (exc_ri | exc_sys | exc_ov);
    take_irq      = irq_w & ie_q & ~exl_q;
    state_d       = state_q;
    code_d        = code_q;
    cause_d       = cause_q;
    exl_d         = exl_q;
    ie_d          = ie_q;
    epc_write_d   = 1'b0;
    epc_pc_d      = 32'h0;
    redirect_d    = 1'b0;
    redirect_pc_d = 32'h0;
    stall_d       = stall_q;

    case (state_q)
      IDLE: begin
        if (sync_exc || take_irq) begin
          if (exc_ri && instr_valid)       code_d = 5'd10;
          else if (exc_sys && instr_valid) code_d = 5'd8;
          else if (exc_ov && instr_valid)  code_d = 5'd12;
          else                             code_d = 5'd0;
          // A nested exception keeps the original EPC untouched.
          epc_write_d = ~exl_q;
          if (!exl_q) epc_pc_d = sync_exc ? pc : pc + 32'd4;
          stall_d = 1'b1;
          state_d = SAVE;
        end else if (instr_valid && eret) begin
          redirect_d    = 1'b1;
          redirect_pc_d = epc_in;
          stall_d       = 1'b1;
          state_d       = RET;
        end
      end
      SAVE: begin
        cause_d       = code_q;
        exl_d         = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = VECTOR_PC;
        state_d       = VECTOR;
      end
      VECTOR: begin
        stall_d = 1'b0;
        state_d = IDLE;
      end
      RET: begin
        exl_d   = 1'b0;
        stall_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      code_q        <= 5'd0;
      cause_q       <= 5'd0;
      exl_q         <= 1'b0;
      ie_q          <= 1'b1;
      epc_write_q   <= 1'b0;
      epc_pc_q      <= 32'h0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      cause_q       <= cause_d;
      exl_q         <= exl_d;
      ie_q          <= ie_d;
      epc_write_q   <= epc_write_d;
      epc_pc_q      <= epc_pc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      stall_q       <= stall_d;
    end
  end

  assign epc_write   = epc_write_q;
  assign epc_pc      = epc_pc_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign stall       = stall_q;
  assign cause       = {25'h0, cause_q, 2'b00};
  assign status      = {30'h0, exl_q, ie_q};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl with directed and random stimulus.
module tb_exc_ctrl;

`ifdef EXC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        instr_valid, exc_ri, exc_sys, exc_ov, eret;
`ifdef EXC_IRQ_EN
  logic        irq;
`endif
  logic [31:0] epc_in;
  logic        epc_write, redirect, stall;
  logic [31:0] epc_pc, cause, status, redirect_pc;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_valid(instr_valid),
    .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_ov(exc_ov), .eret(eret),
`ifdef EXC_IRQ_EN
    .irq(irq),
`endif
    .epc_in(epc_in), .epc_write(epc_write), .epc_pc(epc_pc), .cause(cause),
    .status(status), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit redir; logic [31:0] val; } item_t;
  typedef struct { int eff; logic [31:0] st; logic [31:0] ca; } upd_t;
  item_t exp_q[$];
  upd_t  upd_q[$];
  bit    stall_set[int];

  int checks = 0;
  int failures = 0;

  // Reference state: architectural view only (EXL, cause code, next edge that may accept an event).
  bit          m_exl = 1'b0;
  logic [31:0] m_cause = 32'h0;
  int          m_free = 0;
  int          m_last_eret = -10;
  logic [31:0] cur_st = 32'h1;
  logic [31:0] cur_ca = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model(input int e, input bit rst_n, input bit iv, input bit ri, input bit sy,
                       input bit ov, input bit er, input bit iq, input logic [31:0] pcv,
                       input logic [31:0] epv);
    bit sync, irq_ok;
    logic [31:0] code;
    int keys[$];
    if (!rst_n) begin
      exp_q = exp_q.find(x) with (x.cyc < e);
      upd_q = upd_q.find(x) with (x.eff < e);
      foreach (stall_set[k]) if (k >= e) keys.push_back(k);
      foreach (keys[i]) stall_set.delete(keys[i]);
      upd_q.push_back('{e, 32'h1, 32'h0});
      m_exl = 1'b0; m_cause = 32'h0; m_free = e + 1;
      return;
    end
    if (e < m_free) return;
    sync   = iv && (ri || sy || ov);
    irq_ok = IRQ_EN && iq && !m_exl;
    if (sync || irq_ok) begin
      code = !sync ? 0 : ri ? 10 : sy ? 8 : 12;
      if (!m_exl) exp_q.push_back('{e, 1'b0, sync ? pcv : pcv + 32'd4});
      m_cause = code * 4;
      m_exl = 1'b1;
      exp_q.push_back('{e + 1, 1'b1, 32'h800});
      upd_q.push_back('{e + 1, 32'h3, m_cause});
      stall_set[e] = 1'b1; stall_set[e + 1] = 1'b1;
      m_free = e + 3;
    end else if (iv && er) begin
      exp_q.push_back('{e, 1'b1, epv});
      m_exl = 1'b0;
      upd_q.push_back('{e + 1, 32'h1, m_cause});
      stall_set[e] = 1'b1;
      m_free = e + 2;
      m_last_eret = e;
    end
  endtask

  task automatic drive(input bit rst_n, input bit iv, input bit ri, input bit sy, input bit ov,
                       input bit er, input bit iq, input logic [31:0] pcv, input logic [31:0] epv);
    int e;
    e = cyc + 1;
    reset = rst_n; instr_valid = iv; exc_ri = ri; exc_sys = sy; exc_ov = ov; eret = er;
`ifdef EXC_IRQ_EN
    irq = iq;
`endif
    pc = pcv; epc_in = epv;
    model(e, rst_n, iv, ri, sy, ov, er, iq, pcv, epv);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] epv);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 32'h0, epv);
  endtask

  // Monitor: settles the expected architectural state, then pops strobes as they appear.
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (upd_q.size() > 0 && upd_q[0].eff <= cyc) begin
        cur_st = upd_q[0].st; cur_ca = upd_q[0].ca;
        void'(upd_q.pop_front());
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missed_strobe cycle %0d: got none expected %s %h at cycle %0d",
                 cyc, exp_q[0].redir ? "redirect" : "epc_write", exp_q[0].val, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      chk("status", status, cur_st);
      chk("cause", cause, cur_ca);
      chk("stall", {31'h0, stall}, {31'h0, stall_set.exists(cyc)});
      if (epc_write) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && !exp_q[0].redir) begin
          chk("epc_pc", epc_pc, exp_q[0].val);
          void'(exp_q.pop_front());
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_epc_write cycle %0d: got 1 expected 0", cyc);
        end
      end else chk("epc_pc_idle", epc_pc, 32'h0);
      if (redirect) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].redir) begin
          chk("redirect_pc", redirect_pc, exp_q[0].val);
          void'(exp_q.pop_front());
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_redirect cycle %0d: got 1 expected 0", cyc);
        end
      end else chk("redirect_pc_idle", redirect_pc, 32'h0);
    end
  end

  initial begin
    logic [31:0] epv;
    logic [31:0] pcv;
    bit rn, iv, ri, sy, ov, er, iq;

    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(2, 32'h3014);
    drive(1, 1, 0, 1, 0, 0, 0, 32'h0000_3010, 32'h3014);
    idle(3, 32'h3014);
    drive(1, 1, 0, 0, 0, 1, 0, 32'h0, 32'h3014);
    idle(2, 32'h3014);
    drive(1, 1, 1, 0, 1, 1, 0, 32'h100, 32'h3014);
    idle(3, 32'h3014);
    drive(1, 1, 0, 0, 1, 0, 0, 32'h500, 32'h3014);
    idle(3, 32'h3014);
    drive(1, 0, 0, 0, 0, 0, 1, 32'h200, 32'h3014);
    idle(3, 32'h3014);
    drive(1, 1, 0, 0, 0, 1, 0, 32'h0, 32'h3014);
    idle(2, 32'h3014);
    drive(1, 0, 0, 0, 0, 0, 1, 32'h200, 32'h3014);
    idle(3, 32'h3014);
    drive(1, 1, 0, 0, 0, 1, 0, 32'h0, 32'h3014);
    idle(2, 32'h3014);
    drive(1, 0, 1, 1, 1, 1, 0, 32'h60, 32'h3014);
    idle(1, 32'h3014);
    drive(1, 1, 0, 1, 0, 0, 0, 32'h40, 32'h3014);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h3014);
    idle(4, 32'h3014);

    epv = 32'h3014;
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 39) != 0);
      iv  = $urandom_range(0, 3) != 0;
      ri  = $urandom_range(0, 7) == 0;
      sy  = $urandom_range(0, 7) == 0;
      ov  = $urandom_range(0, 7) == 0;
      er  = $urandom_range(0, 3) == 0;
      iq  = $urandom_range(0, 7) == 0;
      pcv = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (m_last_eret != cyc) epv = $urandom;
      drive(rn, iv, ri, sy, ov, er, iq, pcv, epv);
    end
    idle(6, epv);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The port list SHALL be: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 The port list SHALL include: reset  input  1  synchronous, active-low reset; reset==0 sampled at a rising edge of clk resets the block.
REQ-003 The port list SHALL include: pc  input  32  PC of the instruction completing this cycle.
REQ-004 The port list SHALL include: instr_valid  input  1  instruction completes this cycle.
REQ-005 The port list SHALL include: exc_ri, exc_sys, exc_ov  input  1 each  reserved-instruction, syscall and overflow flags, qualified by instr_valid.
REQ-006 The port list SHALL include: eret  input  1  exception-return instruction, qualified by instr_valid.
REQ-007 The port list SHALL include: irq  input  1  level external interrupt; present only with EXC_IRQ_EN.
REQ-008 The port list SHALL include: epc_in  input  32  current EPC register value.
REQ-009 The port list SHALL include: epc_write  output  1  EPC register write strobe.
REQ-010 The port list SHALL include: epc_pc  output  32  value written to EPC.
REQ-011 The port list SHALL include: cause  output  32  ExcCode in [6:2], all other bits 0.
REQ-012 The port list SHALL include: status  output  32  bit0 IE, bit1 EXL, all other bits 0.
REQ-013 The port list SHALL include: redirect  output  1  fetch redirect strobe.
REQ-014 The port list SHALL include: redirect_pc  output  32  redirect target.
REQ-015 The port list SHALL include: stall  output  1  freezes PC update and register writeback.

Function
REQ-016 The FSM SHALL have states IDLE, SAVE, VECTOR and RET, and only IDLE SHALL accept events.
REQ-017 In IDLE with instr_valid=1, event priority SHALL be exc_ri > exc_sys > exc_ov > irq > eret.
REQ-018 ExcCode SHALL be ri=10, sys=8, ov=12, irq=0.
REQ-019 A taken exception SHALL latch the code and a save PC at the edge and move to SAVE; the save PC is pc for synchronous exceptions and pc+4 (mod 2^32) for irq.
REQ-020 An irq SHALL be taken only when IE=1 and EXL=0; a masked irq SHALL be ignored without latching.
REQ-021 In SAVE, if EXL was 0 at the latching edge, epc_write SHALL be 1 for exactly one cycle with epc_pc equal to the latched save PC.
REQ-022 In SAVE, if EXL was already 1 (nested synchronous exception), epc_write SHALL stay 0.
REQ-023 On the SAVE->VECTOR edge, cause[6:2] SHALL take the latched code and EXL SHALL be set to 1.
REQ-024 In VECTOR, redirect SHALL be 1 with redirect_pc=32'h0000_0800 for one cycle, and the FSM SHALL then return to IDLE.
REQ-025 An eret taken in IDLE SHALL move to RET; in RET, redirect SHALL be 1 with redirect_pc=epc_in, and EXL SHALL clear on the RET->IDLE edge.
REQ-026 An exception and eret asserted in the same cycle SHALL take the exception and drop the eret.
REQ-027 stall SHALL be 1 in SAVE, VECTOR and RET, and 0 in IDLE; all event inputs SHALL be ignored while stall=1.
REQ-028 Exception latency from event edge to redirect SHALL be 2 cycles; eret latency SHALL be 1 cycle.
REQ-029 With instr_valid=0, all event inputs SHALL be ignored except irq, which is taken if unmasked.
REQ-030 epc_pc and redirect_pc SHALL be 0 whenever their strobe is 0.

Reset
REQ-031 While reset==0 at an edge, the FSM SHALL go to IDLE and the outputs SHALL be epc_write=0, epc_pc=0, redirect=0, redirect_pc=0, stall=0, cause=0, status=32'h1 (IE=1, EXL=0).
REQ-032 Reset in any non-IDLE state SHALL abort the sequence with no epc_write or redirect issued afterwards.

Configuration
REQ-033 With macro EXC_IRQ_EN defined, the irq port and the interrupt path SHALL exist.
REQ-034 Without EXC_IRQ_EN, the irq port SHALL be absent, no interrupt SHALL be taken, IE SHALL still reset to 1, and all other behaviour SHALL be unchanged.

Verification
REQ-035 The bench SHALL check: pc=0x0000_3010, exc_sys=1 -> next cycle epc_write=1 with epc_pc=0x0000_3010; following cycle redirect=1 with redirect_pc=0x800; cause=0x20; status=0x3.
REQ-036 The bench SHALL check: exc_ri=1 and exc_ov=1 together at pc=0x100 -> cause=0x28, epc_pc=0x100.
REQ-037 The bench SHALL check: eret with epc_in=0x0000_3014 while status=0x3 -> next cycle redirect=1 with redirect_pc=0x3014; then status=0x1.
REQ-038 The bench SHALL check (EXC_IRQ_EN): irq=1 at pc=0x200 with EXL=0 -> epc_pc=0x204 and cause=0x0; irq=1 with EXL=1 -> no response.
REQ-039 The bench SHALL check: exc_ov with EXL=1 -> no epc_write, redirect to 0x800, cause=0x30.
REQ-040 The bench SHALL check: reset==0 asserted during SAVE -> next cycle all outputs at reset values and no later redirect.
